// File: rtl/cwb_pkg.sv
// Shared types and sizing helpers for the codeword bank loader.
package cwb_pkg;

  // clog2 that never collapses to zero width
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ANTS   = 32;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 64;
  localparam int SETS   = 4;
  localparam int SET_W  = clog2_min1(SETS);
  localparam int ADDR_W = clog2_min1(SETS * DEPTH);
  localparam int IDX_W  = clog2_min1(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    SWAP  = 2'd3
  } cwb_state_e;

  typedef logic [WIDTH*ANTS-1:0] cw_word_t;

endpackage

// File: rtl/cwb_rd_pipe.sv
// Delays {valid, idx} by RD_LAT cycles so the write index lines up with returning ROM data.
module cwb_rd_pipe
  import cwb_pkg::*;
#(
  parameter int RD_LAT = 4,
  parameter int IDX_W  = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_vld,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx
);

  logic [RD_LAT-1:0]            vld_q;
  logic [RD_LAT-1:0][IDX_W-1:0] idx_q;

  // Valid bits cleared on reset so returns of an aborted load are dropped
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q[0] <= i_vld;
      idx_q[0] <= i_idx;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        idx_q[s] <= idx_q[s-1];
      end
    end
  end

  assign o_vld = vld_q[RD_LAT-1];
  assign o_idx = idx_q[RD_LAT-1];

endmodule

// File: rtl/codeword_bank_loader.sv
// Loads one of SETS codebooks from an external ROM and presents it on the active codeword arrays.
// Build option CWB_DOUBLE_BUF_EN: shadow buffer, outputs stay valid and glitch-free through reloads.
module codeword_bank_loader
  import cwb_pkg::*;
#(
  parameter int ANTS   = 32,
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 64,
  parameter int SETS   = 4,
  parameter int RD_LAT = 4,
  parameter int SEL_W  = clog2_min1(SETS),
  localparam int CW_W      = WIDTH * ANTS,
  localparam int ADDR_BITS = clog2_min1(SETS * DEPTH),
  localparam int IDX_BITS  = clog2_min1(DEPTH),
  localparam int DRN_W     = clog2_min1(RD_LAT)
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_load_req,
  input  logic [SEL_W-1:0]             i_load_set,
  output logic                         o_busy,
  output logic                         o_load_done,
  output logic                         o_load_err,
  output logic [SEL_W-1:0]             o_active_set,
  output logic                         o_rom_rden,
  output logic [ADDR_BITS-1:0]         o_rom_addr,
  input  logic [2*CW_W-1:0]            i_rom_rdata,
  output logic [DEPTH-1:0][CW_W-1:0]   o_cw_even,
  output logic [DEPTH-1:0][CW_W-1:0]   o_cw_odd,
  output logic                         o_tvalid
);

  cwb_state_e           state_q, state_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DRN_W-1:0]     drn_q, drn_d;
  logic [SEL_W-1:0]     set_q, set_d;
  logic                 rden_q, rden_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 busy_q;
  logic                 set_ok, accept;

  logic                 wr_vld;
  logic [IDX_BITS-1:0]  wr_idx;

  logic [DEPTH-1:0][CW_W-1:0] act_even_q, act_odd_q;
  logic                       tvalid_q;

  assign set_ok = 32'(i_load_set) < 32'(SETS);
  assign accept = (state_q == IDLE) && i_load_req && set_ok;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    drn_d   = drn_q;
    set_d   = set_q;
    rden_d  = rden_q;
    done_d  = 1'b0;
    // any request not taken is reported: bad set in IDLE, or arriving while busy
    err_d   = i_load_req && !accept;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ISSUE;
          set_d   = i_load_set;
          rden_d  = 1'b1;
          idx_d   = '0;
          addr_d  = ADDR_BITS'(i_load_set) * ADDR_BITS'(DEPTH);
        end
      end
      ISSUE: begin
        if (idx_q == IDX_BITS'(DEPTH - 1)) begin
          rden_d  = 1'b0;
          drn_d   = '0;
          state_d = DRAIN;
        end else begin
          idx_d  = idx_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == DRN_W'(RD_LAT - 1)) state_d = SWAP;
        else                             drn_d   = drn_q + 1'b1;
      end
      SWAP: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      drn_q   <= '0;
      set_q   <= '0;
      rden_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      drn_q   <= drn_d;
      set_q   <= set_d;
      rden_q  <= rden_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  cwb_rd_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (IDX_BITS)
  ) u_rd_pipe (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_vld   (rden_q),
    .i_idx   (idx_q),
    .o_vld   (wr_vld),
    .o_idx   (wr_idx)
  );

`ifdef CWB_DOUBLE_BUF_EN
  logic [DEPTH-1:0][CW_W-1:0] shd_even_q, shd_odd_q;
  logic [SEL_W-1:0]           act_set_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shd_even_q <= '0;
      shd_odd_q  <= '0;
    end else if (wr_vld) begin
      shd_even_q[wr_idx] <= i_rom_rdata[CW_W-1:0];
      shd_odd_q[wr_idx]  <= i_rom_rdata[2*CW_W-1:CW_W];
    end
  end

  // Whole-array copy on one edge: consumers never see a mix of two sets
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      act_even_q <= '0;
      act_odd_q  <= '0;
      act_set_q  <= '0;
      tvalid_q   <= 1'b0;
    end else if (state_q == SWAP) begin
      act_even_q <= shd_even_q;
      act_odd_q  <= shd_odd_q;
      act_set_q  <= set_q;
      tvalid_q   <= 1'b1;
    end
  end

  assign o_active_set = act_set_q;
`else
  // Single buffer: returns land directly on the outputs, so they are flagged invalid while loading
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      act_even_q <= '0;
      act_odd_q  <= '0;
      tvalid_q   <= 1'b0;
    end else begin
      if (wr_vld) begin
        act_even_q[wr_idx] <= i_rom_rdata[CW_W-1:0];
        act_odd_q[wr_idx]  <= i_rom_rdata[2*CW_W-1:CW_W];
      end
      if (accept)                 tvalid_q <= 1'b0;
      else if (state_q == SWAP)   tvalid_q <= 1'b1;
    end
  end

  assign o_active_set = set_q;
`endif

  assign o_busy      = busy_q;
  assign o_load_done = done_q;
  assign o_load_err  = err_q;
  assign o_rom_rden  = rden_q;
  assign o_rom_addr  = addr_q;
  assign o_cw_even   = act_even_q;
  assign o_cw_odd    = act_odd_q;
  assign o_tvalid    = tvalid_q;

endmodule
